pll_phase_stepper: RTL and testbench

PLL_PHASE_STEPPER -- requirements
Module: pll_phase_stepper

---
 rtl/pll_phase_pkg.sv | 44 ++++
 rtl/pll_phase_stepper_if.sv | 38 +++
 rtl/sync_2ff.sv | 32 +++
 rtl/pll_phase_stepper.sv | 211 +++++++++++++++++++++
 tb/tb_pll_phase_stepper.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pll_phase_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_phase_pkg
// Description : Shared state encoding, error codes and sizing helpers for the
//               PLL dynamic phase stepper.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_phase_pkg;

    // Controller states; the encoding is explicit so that it is stable across tools.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        SETUP     = 3'd2,
        ASSERT_EN = 3'd3,
        WAIT_LOW  = 3'd4,
        WAIT_HIGH = 3'd5,
        FINISH    = 3'd6
    } state_t;

    // Completion status reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LOCK    = 2'b10;

    // Largest of three terms, used to size the shared cycle counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Bits needed to hold values 0..max_val, never less than one.
    function automatic int width_for(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_phase_stepper_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_phase_stepper_if
// Description : Request handshake bundle for the PLL phase stepper. The
//               requester drives valid plus payload, the stepper returns ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_phase_stepper_if #(
    parameter int CNTSEL_W = 5,
    parameter int STEP_W   = 8
);

    logic                req_valid;
    logic                req_ready;
    logic [CNTSEL_W-1:0] req_cntsel;
    logic                req_updn;
    logic [STEP_W-1:0]   req_steps;

    // Requester side.
    modport master (
        output req_valid,
        output req_cntsel,
        output req_updn,
        output req_steps,
        input  req_ready
    );

    // Stepper side.
    modport slave (
        input  req_valid,
        input  req_cntsel,
        input  req_updn,
        input  req_steps,
        output req_ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer for a single level signal that is
//               asynchronous to clk. Clears to 0 on reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic d,
    output logic      q
);

    logic meta_q;
    logic sync_q;

    // Two back-to-back flops give the first stage a full cycle to resolve.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module      : pll_phase_stepper
// Description : Drives a PLL dynamic phase-shift port. Each accepted request
//               issues req_steps phase_en pulses on one counter/direction,
//               handshaking each pulse against phase_done and aborting on
//               timeout or loss of PLL lock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_phase_stepper
    import pll_phase_pkg::*;
#(
    parameter int CNTSEL_W     = 5,
    parameter int STEP_W       = 8,
    parameter int EN_CYCLES    = 2,
    parameter int SETUP_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input  wire logic                scanclk,
    input  wire logic                rst_n,
    pll_phase_stepper_if.slave       req,
    input  wire logic                pll_locked,
    input  wire logic                phase_done,
    output logic                     phase_en,
    output logic                     updn,
    output logic [CNTSEL_W-1:0]      cntsel,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    output logic [1:0]               err_code,
    output logic [STEP_W-1:0]        steps_done
);

    // The PLL needs phase_en high for at least two scanclk cycles, and the
    // setup/timeout windows must be at least one cycle to make sense.
    localparam int EN_EFF    = (EN_CYCLES    < 2) ? 2 : EN_CYCLES;
    localparam int SETUP_EFF = (SETUP_CYCLES < 1) ? 1 : SETUP_CYCLES;
    localparam int TO_EFF    = (TIMEOUT      < 1) ? 1 : TIMEOUT;

    // One counter is shared by SETUP, ASSERT_EN and the phase_done wait.
    localparam int CNT_W = width_for(max3(EN_EFF, SETUP_EFF, TO_EFF));

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_EFF - 1);
    localparam logic [CNT_W-1:0] EN_LAST    = CNT_W'(EN_EFF - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TO_EFF - 1);

    // ------------------------------------------------------------------------
    // Synchronized PLL status
    // ------------------------------------------------------------------------
    logic locked_s;
    logic pdone_s;

    sync_2ff u_sync_locked (
        .clk   (scanclk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    sync_2ff u_sync_pdone (
        .clk   (scanclk),
        .rst_n (rst_n),
        .d     (phase_done),
        .q     (pdone_s)
    );

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    state_t              state_q,      state_d;
    logic [CNT_W-1:0]    cnt_q,        cnt_d;
    logic [CNTSEL_W-1:0] cntsel_q,     cntsel_d;
    logic                updn_q,       updn_d;
    logic [STEP_W-1:0]   steps_q,      steps_d;
    logic [STEP_W-1:0]   steps_done_q, steps_done_d;
    logic [1:0]          err_code_q,   err_code_d;

    // Register update; reset returns everything to an idle, quiet PLL port.
    always_ff @(posedge scanclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            cntsel_q     <= '0;
            updn_q       <= 1'b0;
            steps_q      <= '0;
            steps_done_q <= '0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cntsel_q     <= cntsel_d;
            updn_q       <= updn_d;
            steps_q      <= steps_d;
            steps_done_q <= steps_done_d;
            err_code_q   <= err_code_d;
        end
    end

    // Next-state logic. Lock loss outranks timeout, which outranks progress.
    // cntsel/updn are loaded only on accept, so they stay frozen for the
    // whole request and are never disturbed while phase_en is high.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        cntsel_d     = cntsel_q;
        updn_d       = updn_q;
        steps_d      = steps_q;
        steps_done_d = steps_done_q;
        err_code_d   = err_code_q;

        case (state_q)
            IDLE: begin
                if (req.req_valid) begin
                    cntsel_d     = req.req_cntsel;
                    updn_d       = req.req_updn;
                    steps_d      = req.req_steps;
                    steps_done_d = '0;
                    err_code_d   = ERR_NONE;
                    cnt_d        = '0;
                    state_d      = (req.req_steps == '0) ? FINISH : WAIT_LOCK;
                end
            end

            WAIT_LOCK: begin
                if (locked_s) begin
                    cnt_d   = '0;
                    state_d = SETUP;
                end
            end

            SETUP: begin
                if (!locked_s) begin
                    err_code_d = ERR_LOCK;
                    state_d    = FINISH;
                end else if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = ASSERT_EN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            ASSERT_EN: begin
                if (!locked_s) begin
                    err_code_d = ERR_LOCK;
                    state_d    = FINISH;
                end else if (cnt_q == EN_LAST) begin
                    // Counter restarts here so the timeout window opens on WAIT_LOW entry.
                    cnt_d   = '0;
                    state_d = WAIT_LOW;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_LOW: begin
                if (!locked_s) begin
                    err_code_d = ERR_LOCK;
                    state_d    = FINISH;
                end else if (cnt_q >= TO_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!pdone_s) begin
                        state_d = WAIT_HIGH;
                    end
                end
            end

            WAIT_HIGH: begin
                if (!locked_s) begin
                    err_code_d = ERR_LOCK;
                    state_d    = FINISH;
                end else if (cnt_q >= TO_LAST) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = FINISH;
                end else if (pdone_s) begin
                    steps_done_d = steps_done_q + 1'b1;
                    cnt_d        = '0;
                    state_d      = (steps_done_d < steps_q) ? SETUP : FINISH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs decoded from registered state so reset silences them at once.
    // ------------------------------------------------------------------------
    assign phase_en      = (state_q == ASSERT_EN);
    assign busy          = (state_q != IDLE);
    assign req.req_ready = (state_q == IDLE);
    assign done          = (state_q == FINISH) && (err_code_q == ERR_NONE);
    assign err           = (state_q == FINISH) && (err_code_q != ERR_NONE);
    assign cntsel        = cntsel_q;
    assign updn          = updn_q;
    assign err_code      = err_code_q;
    assign steps_done    = steps_done_q;

endmodule
`default_nettype wire

// File: tb/tb_pll_phase_stepper.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_phase_stepper
// Description : Self-checking bench for pll_phase_stepper with a behavioural
//               PLL phase-port model and a queue of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pll_phase_stepper;
    import pll_phase_pkg::*;

    localparam int CW = 5;
    localparam int SW = 8;
    localparam int EN = 2;
    localparam int SU = 2;
    localparam int TO = 15;

    logic          scanclk    = 1'b0;
    logic          rst_n      = 1'b0;
    logic          pll_locked = 1'b0;
    logic          phase_done = 1'b1;
    logic          phase_en, updn, busy, done, err;
    logic [CW-1:0] cntsel;
    logic [1:0]    err_code;
    logic [SW-1:0] steps_done;

    pll_phase_stepper_if #(.CNTSEL_W(CW), .STEP_W(SW)) bus ();

    pll_phase_stepper #(
        .CNTSEL_W     (CW),
        .STEP_W       (SW),
        .EN_CYCLES    (EN),
        .SETUP_CYCLES (SU),
        .TIMEOUT      (TO)
    ) dut (
        .scanclk    (scanclk),
        .rst_n      (rst_n),
        .req        (bus),
        .pll_locked (pll_locked),
        .phase_done (phase_done),
        .phase_en   (phase_en),
        .updn       (updn),
        .cntsel     (cntsel),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_code   (err_code),
        .steps_done (steps_done)
    );

    always #5 scanclk = ~scanclk;

    typedef struct packed {
        logic          is_err;
        logic [1:0]    code;
        logic [SW-1:0] steps;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // PLL model knobs and phase_en monitor counters.
    logic          hang       = 1'b0;
    int            low_len    = 2;
    int            low_cnt    = 0;
    logic          pen_d      = 1'b0;
    int            pulses     = 0;
    int            hi_run     = 0;
    int            low_run    = 100;
    int            bad_width  = 0;
    int            short_gaps = 0;
    int            chg_viol   = 0;
    logic [CW-1:0] cntsel_d   = '0;
    logic          updn_d     = 1'b0;

    // PLL phase port: phase_done drops after a phase_en rise and returns
    // high low_len cycles later unless hang is set. Also audits phase_en.
    always @(posedge scanclk) begin
        pen_d    <= phase_en;
        cntsel_d <= cntsel;
        updn_d   <= updn;
        if (phase_en && !pen_d) begin
            pulses     <= pulses + 1;
            phase_done <= 1'b0;
            low_cnt    <= low_len;
            hi_run     <= 1;
            if (low_run < SU) short_gaps <= short_gaps + 1;
            low_run    <= 0;
        end else begin
            if (low_cnt != 0) low_cnt <= low_cnt - 1;
            else if (!hang)   phase_done <= 1'b1;
            if (phase_en) hi_run  <= hi_run + 1;
            else          low_run <= low_run + 1;
        end
        if (!phase_en && pen_d && rst_n && hi_run != EN) bad_width <= bad_width + 1;
        if (phase_en && pen_d && (cntsel !== cntsel_d || updn !== updn_d)) chg_viol <= chg_viol + 1;
    end

    task automatic send(input logic [CW-1:0] cs, input logic ud, input logic [SW-1:0] st,
                        input bit push, input logic e_err, input logic [1:0] e_code,
                        input logic [SW-1:0] e_steps, input string name);
        @(negedge scanclk);
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready before accept: got %b want 1", name, bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_cntsel = cs;
        bus.req_updn   = ud;
        bus.req_steps  = st;
        if (push) exp_q.push_back('{is_err: e_err, code: e_code, steps: e_steps});
        @(negedge scanclk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, output int cyc);
        exp_t e;
        bit   got;
        got = 1'b0;
        cyc = 0;
        for (int i = 0; i < 600; i++) begin
            if (done === 1'b1 || err === 1'b1) begin
                got = 1'b1;
                cyc = i;
                break;
            end
            @(negedge scanclk);
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s completion: got none within 600 cycles want done/err pulse", name);
        end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got unexpected completion want none", name);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({err, done} !== {e.is_err, ~e.is_err}) begin
                errors++;
                $display("FAIL %s err/done: got %b%b want %b%b", name, err, done, e.is_err, ~e.is_err);
            end
            checks++;
            if (err_code !== e.code) begin
                errors++;
                $display("FAIL %s err_code: got %b want %b", name, err_code, e.code);
            end
            checks++;
            if (steps_done !== e.steps) begin
                errors++;
                $display("FAIL %s steps_done: got %0d want %0d", name, steps_done, e.steps);
            end
            @(negedge scanclk);
            checks++;
            if (done !== 1'b0 || err !== 1'b0 || bus.req_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s after pulse done/err/ready: got %b%b%b want 001", name, done, err, bus.req_ready);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge scanclk);
        checks++;
        if ({phase_en, updn, cntsel, busy, done, err, err_code, steps_done} !== '0) begin
            errors++;
            $display("FAIL reset outputs: got en%b ud%b cs%h busy%b done%b err%b code%b sd%0d want all 0",
                     phase_en, updn, cntsel, busy, done, err, err_code, steps_done);
        end
        rst_n = 1'b1;
        @(negedge scanclk);
        checks++;
        if (bus.req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset release ready/busy: got %b%b want 10", bus.req_ready, busy);
        end
    endtask

    task automatic test_single();
        int p0, bw0, cyc;
        p0 = pulses; bw0 = bad_width;
        pll_locked = 1'b1;
        low_len    = 2;
        send(5'b00001, 1'b1, 8'd1, 1'b1, 1'b0, ERR_NONE, 8'd1, "single");
        wait_result("single", cyc);
        checks++;
        if (pulses - p0 != 1) begin
            errors++;
            $display("FAIL single pulses: got %0d want 1", pulses - p0);
        end
        checks++;
        if (cntsel !== 5'b00001 || updn !== 1'b1) begin
            errors++;
            $display("FAIL single cntsel/updn: got %h/%b want 01/1", cntsel, updn);
        end
        checks++;
        if (bad_width != bw0) begin
            errors++;
            $display("FAIL single phase_en width: got %0d bad pulses want 0", bad_width - bw0);
        end
    endtask

    task automatic test_multi();
        int p0, bw0, sg0, cv0, cyc;
        p0 = pulses; bw0 = bad_width; sg0 = short_gaps; cv0 = chg_viol;
        low_len = 3;
        send(5'h0A, 1'b0, 8'd4, 1'b1, 1'b0, ERR_NONE, 8'd4, "multi");
        wait_result("multi", cyc);
        checks++;
        if (pulses - p0 != 4) begin
            errors++;
            $display("FAIL multi pulses: got %0d want 4", pulses - p0);
        end
        checks++;
        if (short_gaps != sg0 || bad_width != bw0) begin
            errors++;
            $display("FAIL multi pulse shape: got %0d short gaps %0d bad widths want 0 0",
                     short_gaps - sg0, bad_width - bw0);
        end
        checks++;
        if (chg_viol != cv0 || cntsel !== 5'h0A || updn !== 1'b0) begin
            errors++;
            $display("FAIL multi cntsel/updn stability: got %0d changes cs%h ud%b want 0 0a 0",
                     chg_viol - cv0, cntsel, updn);
        end
    endtask

    task automatic test_timeout();
        int p0, cyc;
        p0 = pulses;
        hang = 1'b1;
        send(5'h03, 1'b1, 8'd2, 1'b1, 1'b1, ERR_TIMEOUT, 8'd0, "timeout");
        wait_result("timeout", cyc);
        checks++;
        if (pulses - p0 != 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout pulses/busy: got %0d/%b want 1/0", pulses - p0, busy);
        end
        hang = 1'b0;
        repeat (4) @(negedge scanclk);
    endtask

    task automatic test_lock_loss();
        int  p0, cyc;
        bit  seen;
        p0 = pulses;
        seen = 1'b0;
        low_len = 3;
        send(5'h07, 1'b1, 8'd3, 1'b1, 1'b1, ERR_LOCK, 8'd1, "lock_loss");
        for (int i = 0; i < 300; i++) begin
            if (pulses - p0 == 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge scanclk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL lock_loss second pulse: got %0d pulses want 2", pulses - p0);
        end
        pll_locked = 1'b0;
        wait_result("lock_loss", cyc);
        checks++;
        if (phase_en !== 1'b0 || pulses - p0 != 2) begin
            errors++;
            $display("FAIL lock_loss phase_en/pulses: got %b/%0d want 0/2", phase_en, pulses - p0);
        end
        pll_locked = 1'b1;
        repeat (4) @(negedge scanclk);
    endtask

    task automatic test_zero_and_busy();
        int  p0, cyc, not_ready, idle_busy;
        p0 = pulses;
        send(5'h00, 1'b0, 8'd0, 1'b1, 1'b0, ERR_NONE, 8'd0, "zero");
        wait_result("zero", cyc);
        checks++;
        if (cyc > 2 || pulses != p0) begin
            errors++;
            $display("FAIL zero latency/pulses: got %0d cycles %0d pulses want <=2 0", cyc, pulses - p0);
        end
        send(5'h11, 1'b1, 8'd2, 1'b1, 1'b0, ERR_NONE, 8'd2, "b2b");
        not_ready = 0;
        bus.req_valid  = 1'b1;
        bus.req_cntsel = 5'h1F;
        bus.req_updn   = 1'b0;
        bus.req_steps  = 8'd5;
        for (int i = 0; i < 4; i++) begin
            @(negedge scanclk);
            if (bus.req_ready === 1'b0 && busy === 1'b1) not_ready++;
        end
        bus.req_valid = 1'b0;
        checks++;
        if (not_ready != 4) begin
            errors++;
            $display("FAIL b2b ready while busy: got %0d busy cycles want 4", not_ready);
        end
        wait_result("b2b", cyc);
        idle_busy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge scanclk);
            if (busy !== 1'b0) idle_busy++;
        end
        checks++;
        if (idle_busy != 0 || cntsel !== 5'h11 || pulses - p0 != 2) begin
            errors++;
            $display("FAIL b2b second accept: got busy%0d cs%h pulses%0d want 0 11 2",
                     idle_busy, cntsel, pulses - p0);
        end
    endtask

    task automatic test_reset_mid();
        int  cyc, pulses_seen;
        bit  seen;
        seen = 1'b0;
        send(5'h02, 1'b1, 8'd2, 1'b0, 1'b0, ERR_NONE, 8'd0, "reset_mid");
        for (int i = 0; i < 100; i++) begin
            if (phase_en === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge scanclk);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL reset_mid phase_en: got no assertion want 1 within 100 cycles");
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (phase_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async drop: got en%b busy%b want 0 0", phase_en, busy);
        end
        repeat (2) @(negedge scanclk);
        rst_n = 1'b1;
        pulses_seen = 0;
        for (cyc = 0; cyc < 30; cyc++) begin
            @(negedge scanclk);
            if (done === 1'b1 || err === 1'b1) pulses_seen++;
        end
        checks++;
        if (pulses_seen != 0 || bus.req_ready !== 1'b1 || steps_done !== '0 || err_code !== ERR_NONE) begin
            errors++;
            $display("FAIL reset_mid aftermath: got pulses%0d ready%b sd%0d code%b want 0 1 0 00",
                     pulses_seen, bus.req_ready, steps_done, err_code);
        end
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_cntsel = '0;
        bus.req_updn   = 1'b0;
        bus.req_steps  = '0;
        test_reset();
        test_single();
        test_multi();
        test_timeout();
        test_lock_loss();
        test_zero_and_busy();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
